sequence_serializer: RTL and testbench

SEQUENCE_SERIALIZER -- requirements
Module: sequence_serializer

---
 rtl/sequence_pkg.sv | 18 +
 rtl/sequence_bit_counter.sv | 30 +++
 rtl/sequence_detector_1011.sv | 42 ++++
 rtl/sequence_serializer.sv | 123 ++++++++++++
 tb/tb_sequence_serializer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sequence_pkg.sv
// Shared definitions for the serializer and the downstream 1011 detector.
package sequence_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  typedef enum logic [1:0] {
    DET_S0   = 2'd0,
    DET_S1   = 2'd1,
    DET_S10  = 2'd2,
    DET_S101 = 2'd3
  } det_state_t;

endpackage

// File: rtl/sequence_bit_counter.sv
// Bit position counter for the serializer; wraps to 0 after WIDTH-1.
module sequence_bit_counter
  import sequence_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       load,
  output logic [$clog2(WIDTH)-1:0]   count,
  output logic                       last
);

  localparam int unsigned CW = $clog2(WIDTH);

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || load) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sequence_detector_1011.sv
// Overlapping 1011 detector; consumes one bit per cycle while bit_valid is high.
module sequence_detector_1011
  import sequence_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic bit_valid,
  input  logic sequence_in,
  output logic detected
);

  det_state_t state, state_nxt;
  logic       hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DET_S0;
      detected <= 1'b0;
    end else begin
      state    <= state_nxt;
      detected <= hit;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bit_valid) begin
      case (state)
        DET_S0:   state_nxt = sequence_in ? DET_S1   : DET_S0;
        DET_S1:   state_nxt = sequence_in ? DET_S1   : DET_S10;
        DET_S10:  state_nxt = sequence_in ? DET_S101 : DET_S0;
        DET_S101: state_nxt = sequence_in ? DET_S1   : DET_S10;
        default:  state_nxt = DET_S0;
      endcase
    end
  end

  always_comb begin
    hit = bit_valid && sequence_in && (state == DET_S101);
  end

endmodule

// File: rtl/sequence_serializer.sv
// Parallel-to-serial converter with a one-word holding register and
// gapless back-to-back words; shift_en stalls only the serial side.
module sequence_serializer
  import sequence_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             sequence_in,
  output logic             serial_valid,
  output logic             word_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] hold_reg, shreg, shreg_adv;
  logic             hold_full, seq_bit, done_q;
  logic [CW-1:0]    bit_cnt;
  logic             bit_last;
  logic             accept, start, reload, advance, finish, transfer;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Rotate rather than shift so the outgoing bit always sits at first_bit().
  assign shreg_adv = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], shreg[WIDTH-1]}
                                      : {shreg[0], shreg[WIDTH-1:1]};

  assign in_ready     = ~hold_full;
  assign accept       = in_valid & ~hold_full;
  assign transfer     = start | reload;
  assign serial_valid = (state == SHIFT);
  assign sequence_in  = seq_bit;
  assign word_done    = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_full && shift_en) state_nxt = SHIFT;
      SHIFT:   if (shift_en && bit_last && !hold_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    reload  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: start = hold_full & shift_en;
      SHIFT: begin
        if (shift_en) begin
          if (bit_last) begin
            finish = 1'b1;
            reload = hold_full;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // accept and transfer are mutually exclusive: one needs hold empty, the other full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      seq_bit   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (transfer) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_reg  <= in_data;
      end
      if (transfer) begin
        shreg   <= hold_reg;
        seq_bit <= first_bit(hold_reg);
      end else if (advance) begin
        shreg   <= shreg_adv;
        seq_bit <= first_bit(shreg_adv);
      end else if (finish) begin
        seq_bit <= 1'b0;
      end
    end
  end

  sequence_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  ((state == SHIFT) && shift_en),
    .clear   (state == IDLE),
    .load    (transfer),
    .count   (bit_cnt),
    .last    (bit_last)
  );

  bit_cnt_in_range: assert property (@(posedge clock) disable iff (!reset_n)
    bit_cnt <= CW'(WIDTH - 1));

endmodule

// File: tb/tb_sequence_serializer.sv
// Bench for sequence_serializer (WIDTH=4): cycle table, bit scoreboard, corner sequences.
module tb_sequence_serializer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] in_data = 4'b0000;
  logic       in_valid = 1'b0;
  logic       shift_en = 1'b0;
  logic       rdy_m, sv_m, sq_m, wd_m;
  logic       rdy_l, sv_l, sq_l, wd_l;
  logic       det;

  always #5 clock = ~clock;

  sequence_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .shift_en(shift_en), .sequence_in(sq_m),
    .serial_valid(sv_m), .word_done(wd_m)
  );

  sequence_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .shift_en(shift_en), .sequence_in(sq_l),
    .serial_valid(sv_l), .word_done(wd_l)
  );

  sequence_detector_1011 u_det (
    .clock(clock), .reset_n(reset_n), .bit_valid(sv_m && shift_en),
    .sequence_in(sq_m), .detected(det)
  );

  typedef struct {
    logic [3:0] data;
    logic       valid, sen, rdy, sv, sq, wd, det;
  } vec_t;

  vec_t tbl[$];
  logic q_m[$];
  logic q_l[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic [3:0] d, input logic v, input logic s, input logic r,
                     input logic sv, input logic sq, input logic wd, input logic dt);
    vec_t e;
    e.data = d; e.valid = v; e.sen = s; e.rdy = r;
    e.sv = sv; e.sq = sq; e.wd = wd; e.det = dt;
    tbl.push_back(e);
  endtask

  // Called at the falling edge: pops bits the next rising edge consumes, pushes accepted words.
  task automatic sb_step();
    int j;
    logic b;
    if (!reset_n) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (sv_m && shift_en) begin
        if (q_m.size() == 0) check("sb_msb_underflow", 0, 1'b0, 1'b1);
        else begin b = q_m.pop_front(); check("sb_msb_bit", 0, sq_m, b); end
      end
      if (sv_l && shift_en) begin
        if (q_l.size() == 0) check("sb_lsb_underflow", 0, 1'b0, 1'b1);
        else begin b = q_l.pop_front(); check("sb_lsb_bit", 0, sq_l, b); end
      end
      if (in_valid && rdy_m) begin
        for (int k = 0; k < 4; k++) begin
          j = 3 - k;
          q_m.push_back(in_data[j[1:0]]);
          q_l.push_back(in_data[k[1:0]]);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    sb_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    logic [3:0] w;
    //     data     v  s   rdy sv sq wd det
    add(4'h0,    0, 1,  1, 0, 0, 0, 0);  // 0
    add(4'b1011, 1, 1,  1, 0, 0, 0, 0);  // accepted at edge 2
    add(4'h0,    0, 1,  0, 0, 0, 0, 0);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 0, 0, 0);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 0, 0, 1, 1);
    add(4'h0,    0, 1,  1, 0, 0, 0, 0);
    add(4'b1011, 1, 1,  1, 0, 0, 0, 0);  // 9: back-to-back
    add(4'b0110, 1, 1,  0, 0, 0, 0, 0);
    add(4'b0110, 1, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  0, 1, 0, 0, 0);
    add(4'h0,    0, 1,  0, 1, 1, 0, 0);
    add(4'h0,    0, 1,  0, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 0, 1, 1);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 0, 0, 1);
    add(4'h0,    0, 1,  1, 0, 0, 1, 0);
    add(4'b1011, 1, 1,  1, 0, 0, 0, 0);  // 20: stall
    add(4'h0,    0, 1,  0, 0, 0, 0, 0);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'b0110, 1, 0,  1, 1, 0, 0, 0);
    add(4'h0,    0, 0,  0, 1, 0, 0, 0);
    add(4'h0,    0, 0,  0, 1, 0, 0, 0);
    add(4'h0,    0, 1,  0, 1, 0, 0, 0);
    add(4'h0,    0, 1,  0, 1, 1, 0, 0);
    add(4'h0,    0, 1,  0, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 0, 1, 1);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 1, 0, 0);
    add(4'h0,    0, 1,  1, 1, 0, 0, 1);
    add(4'h0,    0, 1,  1, 0, 0, 1, 0);

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", 0, rdy_m, 1'b1);
    check("rst_valid", 0, sv_m, 1'b0);
    check("rst_seq", 0, sq_m, 1'b0);
    check("rst_done", 0, wd_m, 1'b0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      in_data = tbl[i].data; in_valid = tbl[i].valid; shift_en = tbl[i].sen;
      @(negedge clock);
      check("in_ready", i, rdy_m, tbl[i].rdy);
      check("serial_valid", i, sv_m, tbl[i].sv);
      check("sequence_in", i, sq_m, tbl[i].sq);
      check("word_done", i, wd_m, tbl[i].wd);
      check("detected", i, det, tbl[i].det);
      check("lsb_serial_valid", i, sv_l, tbl[i].sv);
      sb_step();
      @(posedge clock);
      #1;
    end

    // Mid-word reset with a word in flight and another held.
    in_data = 4'b1011; in_valid = 1'b1; shift_en = 1'b1;
    tick();
    in_data = 4'b0110;
    tick();
    check("mw_first_valid", 0, sv_m, 1'b1);
    check("mw_first_bit", 0, sq_m, 1'b1);
    tick();
    in_valid = 1'b0;
    check("mw_second_bit", 0, sq_m, 1'b0);
    check("mw_hold_full", 0, rdy_m, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", 0, sv_m, 1'b0);
    check("async_seq", 0, sq_m, 1'b0);
    check("async_done", 0, wd_m, 1'b0);
    check("async_ready", 0, rdy_m, 1'b1);
    check("async_lsb_valid", 0, sv_l, 1'b0);
    in_data = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    check("rel_ready", 0, rdy_m, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("residual_valid", i, sv_m, 1'b0);
      check("residual_done", i, wd_m, 1'b0);
      check("residual_seq", i, sq_m, 1'b0);
      tick();
    end

    // Bit order for both MSB_FIRST settings on 4'b1101.
    w = 4'b1101;
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      j = 3 - i;
      check("lsb_bit", i, sq_l, w[i[1:0]]);
      check("msb_bit", i, sq_m, w[j[1:0]]);
      check("lsb_valid", i, sv_l, 1'b1);
      tick();
    end
    check("lsb_done", 0, wd_l, 1'b1);
    check("lsb_idle", 0, sv_l, 1'b0);
    check("msb_done", 0, wd_m, 1'b1);
    tick();
    check("done_pulse_end", 0, wd_m, 1'b0);

    check_int("sb_msb_left", q_m.size(), 0);
    check_int("sb_lsb_left", q_l.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
